// File: rtl/top_mod.sv
// Execute/write-back stage of the 8-bit accumulator processor.
// Each instruction takes two clocks: EXEC computes, DONE presents results.
module top_mod (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] StageRegInstr_out,
  input  logic [2:0] StageRegAddrMode_out,
  input  logic [7:0] StageRegData_out,
  input  logic [7:0] StageRegPCtr_out,
  input  logic [7:0] InteruptAdrReg,
  output logic [7:0] ACCout,
  output logic       coutRegout,
  output logic       zeroRegout,
  output logic       overflowRegout,
  output logic [7:0] NextPctr,
  output logic       StageComplete
);

  localparam logic [4:0] OP_NOP = 5'b00000, OP_LDA = 5'b00001, OP_STA = 5'b00010,
                         OP_CLA = 5'b00011, OP_AND = 5'b00100, OP_OR  = 5'b00101,
                         OP_XOR = 5'b00110, OP_NOT = 5'b00111, OP_ADD = 5'b01000,
                         OP_ADC = 5'b01001, OP_SUB = 5'b01010, OP_SBC = 5'b01011,
                         OP_INC = 5'b01100, OP_DEC = 5'b01101, OP_SHL = 5'b01110,
                         OP_SHR = 5'b01111, OP_JMP = 5'b10000, OP_JZ  = 5'b10001,
                         OP_JC  = 5'b10010, OP_JV  = 5'b10011, OP_INT = 5'b10100;

  typedef enum logic {EXEC, DONE} state_t;

  state_t      state, state_next;
  logic [7:0]  mem [16];
  logic [7:0]  pc_sum, operand, pc_inc;
  logic [3:0]  ea;
  logic        is_imm;
  logic [7:0]  ar_b;
  logic        ar_cin, ar_sub, ar_v;
  logic [8:0]  arith;
  logic [7:0]  acc_n, npc_n;
  logic        c_n, z_n, v_n, mem_we;

  // Operand resolution; immediate forms (000 and 1xx) use Data directly,
  // which also makes the operand double as the jump target in every mode.
  always_comb begin
    pc_sum = StageRegPCtr_out + StageRegData_out;
    is_imm = (StageRegAddrMode_out == 3'b000) || StageRegAddrMode_out[2];
    case (StageRegAddrMode_out)
      3'b010:  ea = mem[StageRegData_out[3:0]][3:0];
      3'b011:  ea = pc_sum[3:0];
      default: ea = StageRegData_out[3:0];
    endcase
    operand = is_imm ? StageRegData_out : mem[ea];
    pc_inc  = StageRegPCtr_out + 8'd1;
  end

  // Shared adder/subtractor; arith[8] is carry for adds and borrow for subtracts.
  assign ar_sub = (StageRegInstr_out == OP_SUB) || (StageRegInstr_out == OP_SBC) ||
                  (StageRegInstr_out == OP_DEC);
  assign ar_b   = ((StageRegInstr_out == OP_INC) || (StageRegInstr_out == OP_DEC)) ? 8'd1 : operand;
  assign ar_cin = ((StageRegInstr_out == OP_ADC) || (StageRegInstr_out == OP_SBC)) ? coutRegout : 1'b0;
  assign arith  = ar_sub ? ({1'b0, ACCout} - {1'b0, ar_b} - {8'd0, ar_cin})
                         : ({1'b0, ACCout} + {1'b0, ar_b} + {8'd0, ar_cin});
  assign ar_v   = ar_sub ? ((ACCout[7] != ar_b[7]) && (arith[7] != ACCout[7]))
                         : ((ACCout[7] == ar_b[7]) && (arith[7] != ACCout[7]));

  always_comb begin
    state_next    = (state == EXEC) ? DONE : EXEC;
    StageComplete = (state == DONE);
    acc_n  = ACCout;
    c_n    = coutRegout;
    z_n    = zeroRegout;
    v_n    = overflowRegout;
    npc_n  = pc_inc;
    mem_we = 1'b0;
    case (StageRegInstr_out)
      OP_LDA: begin acc_n = operand;           v_n = 1'b0; z_n = (acc_n == 8'd0); end
      OP_STA: mem_we = 1'b1;
      OP_CLA: begin acc_n = 8'd0;              v_n = 1'b0; z_n = 1'b1; end
      OP_AND: begin acc_n = ACCout & operand;  v_n = 1'b0; z_n = (acc_n == 8'd0); end
      OP_OR:  begin acc_n = ACCout | operand;  v_n = 1'b0; z_n = (acc_n == 8'd0); end
      OP_XOR: begin acc_n = ACCout ^ operand;  v_n = 1'b0; z_n = (acc_n == 8'd0); end
      OP_NOT: begin acc_n = ~ACCout;           v_n = 1'b0; z_n = (acc_n == 8'd0); end
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_INC, OP_DEC: begin
        acc_n = arith[7:0];
        c_n   = arith[8];
        v_n   = ar_v;
        z_n   = (arith[7:0] == 8'd0);
      end
      OP_SHL: begin acc_n = {ACCout[6:0], 1'b0}; c_n = ACCout[7]; v_n = 1'b0; z_n = (acc_n == 8'd0); end
      OP_SHR: begin acc_n = {1'b0, ACCout[7:1]}; c_n = ACCout[0]; v_n = 1'b0; z_n = (acc_n == 8'd0); end
      OP_JMP: npc_n = operand;
      OP_JZ:  if (zeroRegout)     npc_n = operand;
      OP_JC:  if (coutRegout)     npc_n = operand;
      OP_JV:  if (overflowRegout) npc_n = operand;
      OP_INT: npc_n = InteruptAdrReg;
      default: ;
    endcase
  end

  // Results commit on the EXEC->DONE edge; reset aborts any pending write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= EXEC;
      ACCout         <= 8'd0;
      coutRegout     <= 1'b0;
      zeroRegout     <= 1'b0;
      overflowRegout <= 1'b0;
      NextPctr       <= 8'd0;
      for (int i = 0; i < 16; i++) mem[i] <= 8'd0;
    end else begin
      state <= state_next;
      if (state == EXEC) begin
        ACCout         <= acc_n;
        coutRegout     <= c_n;
        zeroRegout     <= z_n;
        overflowRegout <= v_n;
        NextPctr       <= npc_n;
        if (mem_we) mem[ea] <= ACCout;
      end
    end
  end

endmodule

// File: tb/tb_top_mod.sv
// Directed bench for the execute/write-back stage: one task per scenario,
// expected values worked out by hand from the instruction semantics.
module tb_top_mod;

  localparam logic [4:0] LDA = 5'b00001, STA = 5'b00010, CLA = 5'b00011,
                         AND_ = 5'b00100, OR_ = 5'b00101, XOR_ = 5'b00110,
                         NOT_ = 5'b00111, ADD = 5'b01000, ADC = 5'b01001,
                         SUB = 5'b01010, SBC = 5'b01011, INC = 5'b01100,
                         DEC = 5'b01101, SHL = 5'b01110, SHR = 5'b01111,
                         JMP = 5'b10000, JZ = 5'b10001, JC = 5'b10010,
                         JV = 5'b10011, INT = 5'b10100, NOP_X = 5'b11111;
  localparam logic [2:0] IMM = 3'b000, DIR = 3'b001, IND = 3'b010, PCR = 3'b011;

  logic       clk, reset;
  logic [4:0] instr;
  logic [2:0] mode;
  logic [7:0] data, pc, int_adr;
  logic [7:0] acc, npc;
  logic       cout, zero, ovf, done;

  int vectors = 0;
  int miscompares = 0;

  top_mod dut (
    .clk(clk), .reset(reset),
    .StageRegInstr_out(instr), .StageRegAddrMode_out(mode),
    .StageRegData_out(data), .StageRegPCtr_out(pc),
    .InteruptAdrReg(int_adr),
    .ACCout(acc), .coutRegout(cout), .zeroRegout(zero),
    .overflowRegout(ovf), .NextPctr(npc), .StageComplete(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one instruction and wait (bounded) for its StageComplete pulse.
  task automatic exec_instr(input logic [4:0] o, input logic [2:0] m,
                            input logic [7:0] d, input logic [7:0] p);
    instr = o; mode = m; data = d; pc = p;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) break;
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL timeout op=%b: StageComplete never rose", o);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; int_adr = 8'd0;
    instr = ADD; mode = IMM; data = 8'd4; pc = 8'd6;
    repeat (2) @(negedge clk);
    vectors++;
    if ({acc, cout, zero, ovf, npc, done} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected 0", {acc, cout, zero, ovf, npc, done});
    end
    reset = 1'b0;
    exec_instr(ADD, IMM, 8'd4, 8'd6);
    vectors++;
    if ({acc, cout, zero, ovf, npc} !== {8'd4, 3'b000, 8'd7}) begin
      miscompares++;
      $display("FAIL first_add: got %h expected %h", {acc, cout, zero, ovf, npc}, {8'd4, 3'b000, 8'd7});
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL pulse_width: got StageComplete=%b expected 0", done);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] e_acc;
    logic       e_c, e_z, e_v;
    for (int i = 2; i <= 64; i++) begin
      exec_instr(ADD, IMM, 8'd4, 8'd6);
      e_acc = 8'(4 * i);
      e_c = (i == 64); e_z = (i == 64); e_v = (i == 32);
      vectors++;
      if ({acc, cout, zero, ovf, npc} !== {e_acc, e_c, e_z, e_v, 8'd7}) begin
        miscompares++;
        $display("FAIL add_chain step %0d: got %h expected %h", i,
                 {acc, cout, zero, ovf, npc}, {e_acc, e_c, e_z, e_v, 8'd7});
      end
    end
  endtask

  task automatic test_overflow;
    exec_instr(LDA, IMM, 8'h7F, 8'h20);
    exec_instr(ADD, IMM, 8'h01, 8'h20);
    vectors++;
    if ({acc, cout, zero, ovf, npc} !== {8'h80, 3'b001, 8'h21}) begin
      miscompares++;
      $display("FAIL add_overflow: got %h expected %h", {acc, cout, zero, ovf, npc}, {8'h80, 3'b001, 8'h21});
    end
    exec_instr(SUB, IMM, 8'h81, 8'h20);
    vectors++;
    if ({acc, cout, zero, ovf, npc} !== {8'hFF, 3'b100, 8'h21}) begin
      miscompares++;
      $display("FAIL sub_borrow: got %h expected %h", {acc, cout, zero, ovf, npc}, {8'hFF, 3'b100, 8'h21});
    end
  endtask

  task automatic test_memory;
    exec_instr(LDA, IMM, 8'h5A, 8'h00);
    exec_instr(STA, DIR, 8'h03, 8'h01);
    exec_instr(CLA, IMM, 8'h00, 8'h02);
    exec_instr(LDA, DIR, 8'h03, 8'h03);
    vectors++;
    if ({acc, zero} !== {8'h5A, 1'b0}) begin
      miscompares++;
      $display("FAIL load_direct: got %h expected %h", {acc, zero}, {8'h5A, 1'b0});
    end
    exec_instr(LDA, IMM, 8'h03, 8'h04);
    exec_instr(STA, DIR, 8'h02, 8'h05);
    exec_instr(CLA, IMM, 8'h00, 8'h06);
    vectors++;
    if ({acc, zero} !== {8'h00, 1'b1}) begin
      miscompares++;
      $display("FAIL cla: got %h expected %h", {acc, zero}, {8'h00, 1'b1});
    end
    exec_instr(LDA, IND, 8'h02, 8'h07);
    vectors++;
    if ({acc, zero} !== {8'h5A, 1'b0}) begin
      miscompares++;
      $display("FAIL load_indirect: got %h expected %h", {acc, zero}, {8'h5A, 1'b0});
    end
  endtask

  task automatic test_jump;
    exec_instr(CLA, IMM, 8'h00, 8'h2F);
    exec_instr(JZ, IMM, 8'h20, 8'h30);
    vectors++;
    if ({acc, cout, zero, ovf, npc} !== {8'h00, 3'b110, 8'h20}) begin
      miscompares++;
      $display("FAIL jz_taken: got %h expected %h", {acc, cout, zero, ovf, npc}, {8'h00, 3'b110, 8'h20});
    end
    exec_instr(LDA, IMM, 8'h01, 8'h31);
    exec_instr(JZ, IMM, 8'h20, 8'hFF);
    vectors++;
    if ({acc, cout, zero, ovf, npc} !== {8'h01, 3'b100, 8'h00}) begin
      miscompares++;
      $display("FAIL jz_not_taken_wrap: got %h expected %h", {acc, cout, zero, ovf, npc}, {8'h01, 3'b100, 8'h00});
    end
  endtask

  task automatic test_int_and_reset;
    int_adr = 8'd9;
    exec_instr(INT, IMM, 8'h00, 8'h33);
    vectors++;
    if ({acc, cout, zero, ovf, npc} !== {8'h01, 3'b100, 8'h09}) begin
      miscompares++;
      $display("FAIL int_redirect: got %h expected %h", {acc, cout, zero, ovf, npc}, {8'h01, 3'b100, 8'h09});
    end
    instr = STA; mode = DIR; data = 8'h00; pc = 8'h34;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    vectors++;
    if ({acc, cout, zero, ovf, npc, done} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_mid: got %h expected 0", {acc, cout, zero, ovf, npc, done});
    end
    instr = 5'b00000;
    @(negedge clk);
    reset = 1'b0;
    exec_instr(LDA, DIR, 8'h00, 8'h00);
    vectors++;
    if ({acc, zero, npc} !== {8'h00, 1'b1, 8'h01}) begin
      miscompares++;
      $display("FAIL aborted_store: got %h expected %h", {acc, zero, npc}, {8'h00, 1'b1, 8'h01});
    end
  endtask

  typedef struct packed {
    logic [4:0] op; logic [2:0] m; logic [7:0] d;
    logic [7:0] acc; logic c, z, v; logic [7:0] npc;
  } vec_t;

  // Chained ALU/branch vectors starting from reset state (C=Z=V=0), PC=0x10.
  task automatic test_alu;
    vec_t tbl[19];
    tbl[0]  = '{LDA,  IMM, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h11};
    tbl[1]  = '{ADD,  IMM, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 8'h11};
    tbl[2]  = '{ADC,  IMM, 8'h05, 8'h06, 1'b0, 1'b0, 1'b0, 8'h11};
    tbl[3]  = '{SBC,  IMM, 8'h07, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h11};
    tbl[4]  = '{SBC,  IMM, 8'h00, 8'hFE, 1'b0, 1'b0, 1'b0, 8'h11};
    tbl[5]  = '{AND_, IMM, 8'h0F, 8'h0E, 1'b0, 1'b0, 1'b0, 8'h11};
    tbl[6]  = '{OR_,  IMM, 8'hF0, 8'hFE, 1'b0, 1'b0, 1'b0, 8'h11};
    tbl[7]  = '{XOR_, IMM, 8'hFE, 8'h00, 1'b0, 1'b1, 1'b0, 8'h11};
    tbl[8]  = '{NOT_, IMM, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h11};
    tbl[9]  = '{SHL,  IMM, 8'h00, 8'hFE, 1'b1, 1'b0, 1'b0, 8'h11};
    tbl[10] = '{SHR,  IMM, 8'h00, 8'h7F, 1'b0, 1'b0, 1'b0, 8'h11};
    tbl[11] = '{INC,  IMM, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1, 8'h11};
    tbl[12] = '{DEC,  IMM, 8'h00, 8'h7F, 1'b0, 1'b0, 1'b1, 8'h11};
    tbl[13] = '{JC,   IMM, 8'h40, 8'h7F, 1'b0, 1'b0, 1'b1, 8'h11};
    tbl[14] = '{JV,   IMM, 8'h40, 8'h7F, 1'b0, 1'b0, 1'b1, 8'h40};
    tbl[15] = '{STA,  DIR, 8'h05, 8'h7F, 1'b0, 1'b0, 1'b1, 8'h11};
    tbl[16] = '{LDA,  PCR, 8'hF5, 8'h7F, 1'b0, 1'b0, 1'b0, 8'h11};
    tbl[17] = '{JMP,  DIR, 8'h05, 8'h7F, 1'b0, 1'b0, 1'b0, 8'h7F};
    tbl[18] = '{NOP_X, IMM, 8'h00, 8'h7F, 1'b0, 1'b0, 1'b0, 8'h11};
    for (int i = 0; i < 19; i++) begin
      exec_instr(tbl[i].op, tbl[i].m, tbl[i].d, 8'h10);
      vectors++;
      if ({acc, cout, zero, ovf, npc} !== {tbl[i].acc, tbl[i].c, tbl[i].z, tbl[i].v, tbl[i].npc}) begin
        miscompares++;
        $display("FAIL alu row %0d op=%b: got %h expected %h", i, tbl[i].op,
                 {acc, cout, zero, ovf, npc}, {tbl[i].acc, tbl[i].c, tbl[i].z, tbl[i].v, tbl[i].npc});
      end
    end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_overflow;
    test_memory;
    test_jump;
    test_int_and_reset;
    test_alu;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
